otfs_frame_scheduler: RTL and testbench



---
 rtl/otfs_pkg.sv | 24 ++
 rtl/otfs_frame_scheduler_if.sv | 42 ++++
 rtl/otfs_block_counter.sv | 27 ++
 rtl/otfs_frame_scheduler.sv | 119 +++++++++++
 tb/tb_otfs_frame_scheduler.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/otfs_pkg.sv
// Shared constants, state encoding and error-bit positions for the OTFS frame scheduler.
package otfs_pkg;

  localparam int LOG2_M    = 6;
  localparam int LOG2_N    = 6;
  localparam int CNT_W     = LOG2_M + LOG2_N;
  localparam int FRAME_LEN = 1 << CNT_W;

  localparam int                   CFG_WIDTH = 8;
  localparam logic [CFG_WIDTH-1:0] CFG_WORD  = 8'h00;

  localparam int ERR_TLAST_UNEXPECTED  = 0;
  localparam int ERR_TLAST_MISSING     = 1;
  localparam int ERR_OUT_LAST_MISALIGN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_FEED,
    S_DRAIN,
    S_READOUT
  } state_t;

endpackage

// File: rtl/otfs_frame_scheduler_if.sv
// Handshake bundle between the frame scheduler and its symbol source, FFT core, buffer and reader.
interface otfs_frame_scheduler_if #(
  parameter int CNT_W     = otfs_pkg::CNT_W,
  parameter int CFG_WIDTH = otfs_pkg::CFG_WIDTH
);
  logic                 Start;
  logic                 Busy;
  logic                 FrameDone;
  logic [2:0]           ErrStatus;
  logic                 SymValid;
  logic                 SymReady;
  logic [CFG_WIDTH-1:0] CfgTdata;
  logic                 CfgTvalid;
  logic                 CfgTready;
  logic                 FftInValid;
  logic                 FftInReady;
  logic                 FftInLast;
  logic                 FftOutValid;
  logic                 FftOutLast;
  logic                 EvtTlastUnexpected;
  logic                 EvtTlastMissing;
  logic                 BufWrEn;
  logic [CNT_W-1:0]     BufWrAddr;
  logic                 RdStart;
  logic                 RdDone;

  // Scheduler side.
  modport master (
    input  Start, SymValid, CfgTready, FftInReady, FftOutValid, FftOutLast,
           EvtTlastUnexpected, EvtTlastMissing, RdDone,
    output Busy, FrameDone, ErrStatus, SymReady, CfgTdata, CfgTvalid,
           FftInValid, FftInLast, BufWrEn, BufWrAddr, RdStart
  );

  // Environment side.
  modport slave (
    output Start, SymValid, CfgTready, FftInReady, FftOutValid, FftOutLast,
           EvtTlastUnexpected, EvtTlastMissing, RdDone,
    input  Busy, FrameDone, ErrStatus, SymReady, CfgTdata, CfgTvalid,
           FftInValid, FftInLast, BufWrEn, BufWrAddr, RdStart
  );
endinterface

// File: rtl/otfs_block_counter.sv
// Frame-position counter with FFT-block-last and frame-last flags.
module otfs_block_counter #(
  parameter int LOG2_M = 6,
  parameter int LOG2_N = 6
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     clr,
  input  logic                     en,
  output logic [LOG2_M+LOG2_N-1:0] count,
  output logic                     block_last,
  output logic                     frame_last
);

  // NOTE: sequential state is assigned with <= so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (srst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign block_last = &count[LOG2_M-1:0];
  assign frame_last = &count;

endmodule

// File: rtl/otfs_frame_scheduler.sv
// Sequences one OTFS frame through the FFT: config write, gated symbol feed, output capture, readout hand-off.
module otfs_frame_scheduler
  import otfs_pkg::*;
#(
  parameter int                   LOG2_M    = otfs_pkg::LOG2_M,
  parameter int                   LOG2_N    = otfs_pkg::LOG2_N,
  parameter int                   CFG_WIDTH = otfs_pkg::CFG_WIDTH,
  parameter logic [CFG_WIDTH-1:0] CFG_WORD  = otfs_pkg::CFG_WORD
) (
  input  logic                   Clk,
  input  logic                   Srst,
  otfs_frame_scheduler_if.master bus
);

  localparam int CNT_W = LOG2_M + LOG2_N;

  state_t           state, state_nxt;
  logic             rd_start_q, rd_start_nxt;
  logic             done_q, done_nxt;
  logic [2:0]       err_q, err_nxt;
  logic             feed, collect, start_ok, in_xfer, out_take, out_frame_end;
  logic             in_block_last, in_frame_last, out_block_last, out_frame_last;
  logic [CNT_W-1:0] in_count_unused, out_count;

  assign feed          = (state == S_FEED);
  assign collect       = feed || (state == S_DRAIN);
  assign start_ok      = (state == S_IDLE) && bus.Start;
  assign in_xfer       = feed && bus.SymValid && bus.FftInReady;
  assign out_take      = collect && bus.FftOutValid;
  assign out_frame_end = out_take && out_frame_last;

  // The input position is only consumed through its last flags.
  otfs_block_counter #(.LOG2_M(LOG2_M), .LOG2_N(LOG2_N)) u_in_cnt (
    .clk        (Clk),
    .srst       (Srst),
    .clr        (start_ok),
    .en         (in_xfer),
    .count      (in_count_unused),
    .block_last (in_block_last),
    .frame_last (in_frame_last)
  );

  otfs_block_counter #(.LOG2_M(LOG2_M), .LOG2_N(LOG2_N)) u_out_cnt (
    .clk        (Clk),
    .srst       (Srst),
    .clr        (start_ok),
    .en         (out_take),
    .count      (out_count),
    .block_last (out_block_last),
    .frame_last (out_frame_last)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    rd_start_nxt = 1'b0;
    done_nxt     = 1'b0;
    case (state)
      S_IDLE:    if (bus.Start) state_nxt = S_CONFIG;
      S_CONFIG:  if (bus.CfgTready) state_nxt = S_FEED;
      S_FEED: begin
        if (in_xfer && in_frame_last) begin
          if (out_frame_end) begin
            state_nxt    = S_READOUT;
            rd_start_nxt = 1'b1;
          end else begin
            state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (out_frame_end) begin
          state_nxt    = S_READOUT;
          rd_start_nxt = 1'b1;
        end
      end
      S_READOUT: begin
        // FrameDone is issued while still in READOUT so Busy covers it.
        if (done_q) state_nxt = S_IDLE;
        else if (bus.RdDone) done_nxt = 1'b1;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    err_nxt = start_ok ? 3'b000 : err_q;
    if (bus.EvtTlastUnexpected) err_nxt[ERR_TLAST_UNEXPECTED] = 1'b1;
    if (bus.EvtTlastMissing)    err_nxt[ERR_TLAST_MISSING]    = 1'b1;
    if (out_take && (bus.FftOutLast != out_block_last)) err_nxt[ERR_OUT_LAST_MISALIGN] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Srst) begin
      state      <= S_IDLE;
      rd_start_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      state      <= state_nxt;
      rd_start_q <= rd_start_nxt;
      done_q     <= done_nxt;
      err_q      <= err_nxt;
    end
  end

  assign bus.Busy       = (state != S_IDLE);
  assign bus.FrameDone  = done_q;
  assign bus.RdStart    = rd_start_q;
  assign bus.ErrStatus  = err_q;
  assign bus.CfgTvalid  = (state == S_CONFIG);
  assign bus.CfgTdata   = (state == S_CONFIG) ? CFG_WORD : '0;
  assign bus.FftInValid = feed && bus.SymValid;
  assign bus.SymReady   = feed && bus.FftInReady;
  assign bus.FftInLast  = feed && in_block_last;
  assign bus.BufWrEn    = out_take;
  assign bus.BufWrAddr  = out_count;

endmodule

// File: tb/tb_otfs_frame_scheduler.sv
// Randomised frame-level bench: a transaction-count model predicts every scheduler output each cycle.
module tb_otfs_frame_scheduler;
  import otfs_pkg::*;

  localparam int FL = FRAME_LEN;
  localparam int BL = 1 << LOG2_M;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  otfs_frame_scheduler_if bus ();
  otfs_frame_scheduler dut (.Clk(clk), .Srst(srst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: frame progress expressed as symbols fed / samples collected.
  bit         m_busy, m_cfg, m_rd, m_rdstart, m_done;
  int         m_fed, m_col;
  logic [2:0] m_err;

  // Stimulus knobs and one-shot triggers.
  int sv_pct = 100, rdy_pct = 100, out_pct = 100, cfg_delay = 3;
  bit lat0 = 0, idle_noise = 0, p_start = 0, p_srst = 0;
  int inject_idx = -1, start_at = -1, srst_at = -1, miss_at = -1, unexp_at = -1;

  // Responder state and per-frame observations.
  int fft_pending, fft_idx, cfg_cnt, rd_due = -1;
  int st_xfer, st_sym, st_last, st_badlast, st_cfg, st_rdstart;
  int c_lastout, c_rdstart, c_rddone, c_done;
  logic [2:0] st_err_cfg;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [30:0] dut_outs();
    return {bus.Busy, bus.FrameDone, bus.ErrStatus, bus.SymReady, bus.CfgTdata, bus.CfgTvalid,
            bus.FftInValid, bus.FftInLast, bus.BufWrEn, bus.BufWrAddr, bus.RdStart};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_cfg = 0; m_rd = 0; m_rdstart = 0; m_done = 0;
    m_fed = 0; m_col = 0; m_err = '0;
    fft_pending = 0; fft_idx = 0; cfg_cnt = 0; rd_due = -1;
  endtask

  task automatic step();
    bit feeding, collecting, cfgv, cfg_rdy, xfer, outv, start_acc, nrs, nd;
    @(negedge clk);
    cyc++;
    feeding    = m_busy && !m_cfg && !m_rd && (m_fed < FL);
    collecting = m_busy && !m_cfg && !m_rd && (m_col < FL);
    cfgv       = m_busy && m_cfg;

    bus.SymValid   = (int'($urandom_range(99)) < sv_pct);
    bus.FftInReady = (int'($urandom_range(99)) < rdy_pct);
    cfg_rdy        = cfgv && (cfg_cnt >= cfg_delay - 1);
    bus.CfgTready  = cfg_rdy;
    xfer           = feeding && bus.SymValid && bus.FftInReady;
    if (lat0) outv = xfer;
    else      outv = collecting && (fft_pending > 0) && (int'($urandom_range(99)) < out_pct);
    if (idle_noise && !m_busy) outv = $urandom_range(1) == 1;
    bus.FftOutValid = outv;
    bus.FftOutLast  = (fft_idx % BL == BL - 1) || (fft_idx == inject_idx);
    bus.Start       = p_start || (feeding && m_fed == start_at);
    srst            = p_srst  || (feeding && m_fed == srst_at);
    bus.EvtTlastMissing    = feeding && m_fed == miss_at;
    bus.EvtTlastUnexpected = feeding && m_fed == unexp_at;
    bus.RdDone      = (cyc == rd_due);
    if (bus.Start && !p_start) start_at = -1;
    if (srst && !p_srst) srst_at = -1;
    if (bus.EvtTlastMissing) miss_at = -1;
    if (bus.EvtTlastUnexpected) unexp_at = -1;

    #1;
    check("ctrl",   {bus.Busy, bus.FrameDone, bus.RdStart, bus.ErrStatus},
                    {m_busy, m_rd && m_done, m_rdstart, m_err});
    check("cfg",    {bus.CfgTvalid, bus.CfgTdata}, {cfgv, 8'h00});
    check("fft_in", {bus.FftInValid, bus.SymReady, bus.FftInLast},
                    {feeding && bus.SymValid, feeding && bus.FftInReady, feeding && (m_fed % BL == BL - 1)});
    check("buf",    {bus.BufWrEn, bus.BufWrAddr}, {collecting && outv, 12'(m_col % FL)});

    if (bus.CfgTvalid) st_cfg++;
    if (bus.FftInValid && bus.FftInReady) begin
      st_xfer++;
      if (bus.FftInLast) begin
        st_last++;
        if ((st_xfer - 1) % BL != BL - 1) st_badlast++;
      end
    end
    if (bus.SymValid && bus.SymReady) st_sym++;
    if (bus.BufWrEn && bus.BufWrAddr == 12'(FL - 1)) c_lastout = cyc;
    if (bus.RdStart) begin st_rdstart++; c_rdstart = cyc; end
    if (bus.RdDone) c_rddone = cyc;
    if (bus.FrameDone) c_done = cyc;

    if (srst) begin
      model_reset();
    end else begin
      start_acc = !m_busy && bus.Start;
      if (start_acc) m_err = '0;
      if (bus.EvtTlastUnexpected) m_err[ERR_TLAST_UNEXPECTED] = 1'b1;
      if (bus.EvtTlastMissing)    m_err[ERR_TLAST_MISSING]    = 1'b1;
      if (collecting && outv && (bus.FftOutLast != (m_col % BL == BL - 1)))
        m_err[ERR_OUT_LAST_MISALIGN] = 1'b1;
      cfg_cnt = (cfgv && !cfg_rdy) ? cfg_cnt + 1 : 0;
      if (!lat0 && xfer) fft_pending++;
      if (collecting && outv) begin
        fft_idx++;
        if (!lat0) fft_pending--;
      end
      if (m_rdstart) rd_due = cyc + 10;
      nrs = 0; nd = 0;
      if (start_acc) begin
        m_busy = 1; m_cfg = 1; m_rd = 0; m_fed = 0; m_col = 0;
      end else if (m_busy) begin
        if (m_cfg) begin
          if (cfg_rdy) m_cfg = 0;
        end else if (m_rd) begin
          if (m_done) begin m_busy = 0; m_rd = 0; end
          else if (bus.RdDone) nd = 1;
        end else begin
          if (xfer) m_fed++;
          if (collecting && outv) m_col++;
          if (m_fed == FL && m_col == FL) begin m_rd = 1; nrs = 1; end
        end
      end
      m_rdstart = nrs;
      m_done    = nd;
    end
  endtask

  task automatic run_frame(input int budget);
    int n;
    st_xfer = 0; st_sym = 0; st_last = 0; st_badlast = 0; st_cfg = 0; st_rdstart = 0;
    c_lastout = -1; c_rdstart = -1; c_rddone = -1; c_done = -1;
    fft_idx = 0; fft_pending = 0;
    p_start = 1; step(); p_start = 0;
    step();
    st_err_cfg = bus.ErrStatus;
    n = 0;
    while (m_busy && n < budget) begin step(); n++; end
  endtask

  initial begin
    srst = 1'b1;
    bus.Start = 0; bus.SymValid = 0; bus.CfgTready = 0; bus.FftInReady = 0;
    bus.FftOutValid = 0; bus.FftOutLast = 0; bus.EvtTlastUnexpected = 0;
    bus.EvtTlastMissing = 0; bus.RdDone = 0;
    model_reset();

    p_srst = 1; repeat (3) step(); p_srst = 0;
    step();
    check("reset_outputs", dut_outs(), '0);

    // Frame 1: full-rate feed, 3-cycle config stall, FFT output one cycle behind input.
    run_frame(6000);
    check("f1_cfg_cycles", st_cfg, 3);
    check("f1_xfers", st_xfer, FL);
    check("f1_syms", st_sym, FL);
    check("f1_tlast_count", st_last, 64);
    check("f1_tlast_misplaced", st_badlast, 0);
    check("f1_rdstart_pulses", st_rdstart, 1);
    check("f1_rdstart_lag", c_rdstart - c_lastout, 1);
    check("f1_rddone_lag", c_rddone - c_rdstart, 10);
    check("f1_framedone_lag", c_done - c_rddone, 1);
    check("f1_err", bus.ErrStatus, 3'b000);
    step();
    check("f1_busy_after", bus.Busy, 1'b0);

    // Frame 2: throttled handshakes, bursty FFT output, one unexpected-tlast event.
    sv_pct = 75; rdy_pct = 50; out_pct = 60; cfg_delay = int'($urandom_range(4, 1)); unexp_at = 300;
    run_frame(30000);
    check("f2_xfers", st_xfer, FL);
    check("f2_syms", st_sym, FL);
    check("f2_tlast_count", st_last, 64);
    check("f2_tlast_misplaced", st_badlast, 0);
    check("f2_err", bus.ErrStatus, 3'b001);

    // Spurious FFT output while idle must not write the buffer.
    idle_noise = 1; repeat (20) step(); idle_noise = 0;

    // Frame 3: early tlast at sample 62 plus a tlast-missing event.
    sv_pct = 100; rdy_pct = 100; out_pct = 100; cfg_delay = 1;
    inject_idx = 62; miss_at = 500;
    run_frame(6000);
    inject_idx = -1;
    check("f3_err", bus.ErrStatus, 3'b110);
    check("f3_xfers", st_xfer, FL);

    // Frame 4: errors cleared by Start; last input and last output in the same cycle.
    lat0 = 1; cfg_delay = 2;
    run_frame(6000);
    lat0 = 0;
    check("f4_err_cleared", st_err_cfg, 3'b000);
    check("f4_rdstart_lag", c_rdstart - c_lastout, 1);
    check("f4_xfers", st_xfer, FL);

    // Frame 5: Start ignored mid-feed, then Srst mid-frame.
    start_at = 1000; srst_at = 2000;
    run_frame(6000);
    check("f5_xfers_at_srst", st_xfer, 2001);
    check("f5_tlast_count", st_last, 31);
    step();
    check("f5_srst_outputs", dut_outs(), '0);

    // Frame 6: clean frame after the abort.
    run_frame(6000);
    check("f6_xfers", st_xfer, FL);
    check("f6_tlast_count", st_last, 64);
    check("f6_err", bus.ErrStatus, 3'b000);
    step();
    check("f6_busy_after", bus.Busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
